// File: rtl/envelope_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : envelope_sequencer
// Brief    : Per-strobe multi-step amplitude envelope player fed from a shared
//            one-cycle-latency ROM. Define ENVELOPE_SEQUENCER_LOOP_EN to loop
//            the envelope instead of sustaining its last step.
// Revision : 1.0 - initial release
// ============================================================================
module envelope_sequencer #(
    parameter int unsigned BASE_ADDRESS     = 32'h0,
    parameter int          ROM_ADDR_WIDTH   = 8,
    parameter int          ROM_DATA_WIDTH   = 16,
    parameter int          FIELD_WIDTH      = 4,
    parameter int          INSTRUMENT_WIDTH = 4,
    parameter int          STEP_WIDTH       = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_load_instrument,
    input  logic [INSTRUMENT_WIDTH-1:0] i_instrument,
    input  logic                        i_note_on,
    input  logic                        i_note_off,
    input  logic                        i_strobe,
    output logic                        o_valid,
    output logic [FIELD_WIDTH-1:0]      o_amplitude,
    output logic                        o_busy,
    output logic [ROM_ADDR_WIDTH-1:0]   o_rom_addr,
    input  logic [ROM_DATA_WIDTH-1:0]   i_rom_data
);

    localparam int c_FPW       = ROM_DATA_WIDTH / FIELD_WIDTH;
    localparam int c_FSEL      = $clog2(c_FPW);
    localparam int c_IDXW      = (c_FSEL > 0) ? c_FSEL : 1;
    localparam int c_LEN_WORDS = (2 ** INSTRUMENT_WIDTH) / c_FPW;
    localparam int c_WPI       = (2 ** STEP_WIDTH) / c_FPW;
    localparam logic [ROM_ADDR_WIDTH-1:0] c_LEN_BASE = ROM_ADDR_WIDTH'(BASE_ADDRESS);
    localparam logic [ROM_ADDR_WIDTH-1:0] c_ENV_BASE = ROM_ADDR_WIDTH'(BASE_ADDRESS + c_LEN_WORDS);
    localparam logic [c_IDXW-1:0]         c_IDX_MASK = c_IDXW'(c_FPW - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ZERO     = 3'd1,
        S_LEN_ADDR = 3'd2,
        S_LEN_READ = 3'd3,
        S_ACTIVE   = 3'd4,
        S_ENV_ADDR = 3'd5,
        S_ENV_READ = 3'd6,
        S_VALID    = 3'd7
    } state_t;

    state_t                        r_state;
    state_t                        w_next_state;
    logic [INSTRUMENT_WIDTH-1:0]   r_instrument;
    logic [INSTRUMENT_WIDTH-1:0]   r_inst_latched;
    logic [STEP_WIDTH-1:0]         r_step;
    logic [STEP_WIDTH-1:0]         r_length;
    logic                          r_release;
    logic                          r_valid;
    logic [FIELD_WIDTH-1:0]        r_amplitude;
    logic [INSTRUMENT_WIDTH-1:0]   w_note_inst;
    logic [ROM_ADDR_WIDTH-1:0]     w_len_addr;
    logic [ROM_ADDR_WIDTH-1:0]     w_env_addr;
    logic [ROM_ADDR_WIDTH-1:0]     w_rom_addr;
    logic [c_IDXW-1:0]             w_len_idx;
    logic [c_IDXW-1:0]             w_env_idx;
    logic [FIELD_WIDTH-1:0]        w_fields [c_FPW];

    generate
        for (genvar k = 0; k < c_FPW; k++) begin : g_field
            assign w_fields[k] = i_rom_data[k*FIELD_WIDTH +: FIELD_WIDTH];
        end
    endgenerate

    // A load coincident with note-on must take effect immediately.
    assign w_note_inst = i_load_instrument ? i_instrument : r_instrument;

    assign w_len_idx  = c_IDXW'(r_inst_latched) & c_IDX_MASK;
    assign w_env_idx  = c_IDXW'(r_step) & c_IDX_MASK;
    assign w_len_addr = c_LEN_BASE + ROM_ADDR_WIDTH'(r_inst_latched >> c_FSEL);
    assign w_env_addr = c_ENV_BASE + ROM_ADDR_WIDTH'(r_inst_latched * c_WPI)
                      + ROM_ADDR_WIDTH'(r_step >> c_FSEL);

    always_comb begin
        w_next_state = r_state;
        w_rom_addr   = '0;
        case (r_state)
            S_IDLE:     if (i_strobe) w_next_state = S_ZERO;
            S_ZERO:     w_next_state = S_IDLE;
            S_LEN_ADDR: begin
                w_rom_addr   = w_len_addr;
                w_next_state = S_LEN_READ;
            end
            S_LEN_READ: w_next_state = S_ACTIVE;
            S_ACTIVE:   if (i_strobe) w_next_state = r_release ? S_ZERO : S_ENV_ADDR;
            S_ENV_ADDR: begin
                w_rom_addr   = w_env_addr;
                w_next_state = S_ENV_READ;
            end
            S_ENV_READ: w_next_state = S_VALID;
            S_VALID:    w_next_state = S_ACTIVE;
            default:    w_next_state = S_IDLE;
        endcase
        if (i_note_on) w_next_state = S_LEN_ADDR;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    // Valid and the zero amplitude are registered on entry to ZERO/VALID so
    // each pulse lands in the same cycle as that state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_instrument   <= '0;
            r_inst_latched <= '0;
            r_step         <= '0;
            r_length       <= '0;
            r_release      <= 1'b0;
            r_valid        <= 1'b0;
            r_amplitude    <= '0;
        end else begin
            r_valid <= 1'b0;
            if (i_load_instrument) r_instrument <= i_instrument;
            if (i_note_on) begin
                r_inst_latched <= w_note_inst;
                r_step         <= '0;
                r_release      <= 1'b0;
            end else begin
                if (i_note_off && (r_state != S_IDLE)) r_release <= 1'b1;
                case (r_state)
                    S_IDLE: if (i_strobe) begin
                        r_valid     <= 1'b1;
                        r_amplitude <= '0;
                    end
                    S_ACTIVE: if (i_strobe && r_release) begin
                        r_valid     <= 1'b1;
                        r_amplitude <= '0;
                    end
                    S_LEN_READ: r_length <= STEP_WIDTH'(w_fields[w_len_idx]);
                    S_ENV_READ: begin
                        r_amplitude <= w_fields[w_env_idx];
                        r_valid     <= 1'b1;
                    end
                    S_VALID: begin
`ifdef ENVELOPE_SEQUENCER_LOOP_EN
                        r_step <= (r_step == r_length) ? '0 : r_step + 1'b1;
`else
                        if (r_step != r_length) r_step <= r_step + 1'b1;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_valid     = r_valid;
    assign o_amplitude = r_amplitude;
    assign o_busy      = (r_state != S_IDLE) && (r_state != S_ACTIVE);
    assign o_rom_addr  = w_rom_addr;

endmodule
`default_nettype wire

// File: tb/tb_envelope_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_envelope_sequencer
// Brief    : Self-checking bench for envelope_sequencer (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_envelope_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [3:0]  inst = '0;
    logic        note_on = 1'b0;
    logic        note_off = 1'b0;
    logic        strobe = 1'b0;
    logic        valid;
    logic [3:0]  amplitude;
    logic        busy;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic [15:0] rom [256];

    int errors = 0;
    int checks = 0;
    logic [3:0] got [$];

`ifdef ENVELOPE_SEQUENCER_LOOP_EN
    logic [3:0] s1_amps [5] = '{4'hC, 4'h5, 4'hB, 4'hC, 4'h5};
    logic [3:0] s2_amps [7] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h1};
    logic [7:0] s2_addr [7] = '{8'd24, 8'd24, 8'd24, 8'd24, 8'd25, 8'd25, 8'd24};
`else
    logic [3:0] s1_amps [5] = '{4'hC, 4'h5, 4'hB, 4'hB, 4'hB};
    logic [3:0] s2_amps [7] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h6};
    logic [7:0] s2_addr [7] = '{8'd24, 8'd24, 8'd24, 8'd24, 8'd25, 8'd25, 8'd25};
`endif

    envelope_sequencer dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_load_instrument (load),
        .i_instrument      (inst),
        .i_note_on         (note_on),
        .i_note_off        (note_off),
        .i_strobe          (strobe),
        .o_valid           (valid),
        .o_amplitude       (amplitude),
        .o_busy            (busy),
        .o_rom_addr        (rom_addr),
        .i_rom_data        (rom_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each accepted request becomes a list of per-cycle output descriptors.
    typedef struct packed {
        logic [7:0] addr;
        logic       v;
        logic [3:0] amp;
    } ent_t;

    ent_t       q [$];
    ent_t       e;
    bit         m_play, m_rel, cur_busy;
    int         m_inst, m_len, m_step;
    logic [3:0] m_instreg;
    logic       exp_valid, exp_busy;
    logic [3:0] exp_amp;
    logic [7:0] exp_addr;

    function automatic int rom_field(int word, int k);
        return int'((rom[word & 255] >> (4 * k)) & 16'hF);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_play = 0; m_rel = 0; m_step = 0; m_inst = 0; m_len = 0;
            m_instreg = '0;
            exp_valid = 0; exp_busy = 0; exp_amp = '0; exp_addr = '0;
        end else begin
            cur_busy = exp_busy;
            if (note_on) begin
                m_inst = load ? int'(inst) : int'(m_instreg);
                m_len  = rom_field(m_inst / 4, m_inst % 4);
                m_step = 0; m_rel = 0; m_play = 1;
                q.delete();
                q.push_back('{8'(m_inst / 4), 1'b0, 4'h0});
                q.push_back('{8'h0, 1'b0, 4'h0});
            end else begin
                if (strobe && !cur_busy) begin
                    if (!m_play || m_rel) begin
                        q.push_back('{8'h0, 1'b1, 4'h0});
                        m_play = 0;
                    end else begin
                        q.push_back('{8'(4 + m_inst * 4 + m_step / 4), 1'b0, 4'h0});
                        q.push_back('{8'h0, 1'b0, 4'h0});
                        q.push_back('{8'h0, 1'b1, 4'(rom_field(4 + m_inst * 4 + m_step / 4, m_step % 4))});
`ifdef ENVELOPE_SEQUENCER_LOOP_EN
                        m_step = (m_step == m_len) ? 0 : (m_step + 1) % 16;
`else
                        if (m_step != m_len) m_step = (m_step + 1) % 16;
`endif
                    end
                end
                if (note_off && (m_play || cur_busy)) m_rel = 1;
            end
            if (load) m_instreg = inst;
            if (q.size() > 0) begin
                e = q.pop_front();
                exp_addr = e.addr; exp_valid = e.v; exp_busy = 1;
                if (e.v) exp_amp = e.amp;
            end else begin
                exp_addr = '0; exp_valid = 0; exp_busy = 0;
            end
        end
        #1;
        chk("valid", 32'(valid), 32'(exp_valid));
        chk("amplitude", 32'(amplitude), 32'(exp_amp));
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("rom_addr", 32'(rom_addr), 32'(exp_addr));
        if (valid === 1'b1) got.push_back(amplitude);
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit s, input bit on, input bit off, input bit ld,
                        input logic [3:0] ins, input bit r);
        @(negedge clk);
        rst = r; strobe = s; note_on = on; note_off = off; load = ld; inst = ins;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 4'h0, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 16'(i * 40503 + 7);
        rom[0]  = 16'h0302;
        rom[1]  = 16'h7359;
        rom[4]  = 16'h0B5C;
        rom[24] = 16'h4321;
        rom[25] = 16'h8765;

        step(0, 0, 0, 0, 4'h0, 1);
        step(0, 0, 0, 0, 4'h0, 1);
        chk("reset_valid", 32'(valid), 0);
        chk("reset_amp", 32'(amplitude), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_addr", 32'(rom_addr), 0);

        // Strobe from IDLE answers with a zero one cycle later
        step(1, 0, 0, 0, 4'h0, 0);
        chk("idle_zero_valid", 32'(valid), 1);
        chk("idle_zero_amp", 32'(amplitude), 0);
        idle(1);

        // Instrument 0, L=2
        step(0, 0, 0, 1, 4'h0, 0);
        step(0, 1, 0, 0, 4'h0, 0);
        idle(2);
        got.delete();
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 0, 4'h0, 0); chk("s1_lat1", 32'(valid), 0);
            idle(1);                   chk("s1_lat2", 32'(valid), 0);
            idle(1);                   chk("s1_lat3", 32'(valid), 1);
            chk("s1_amp", 32'(amplitude), 32'(s1_amps[i]));
            idle(1);                   chk("s1_width", 32'(valid), 0);
            idle(1);
        end
        chk("s1_count", 32'(got.size()), 5);

        // Instrument 5 loaded with bypass: length word 1, envelope base 24
        step(0, 1, 0, 1, 4'h5, 0); chk("s2_len_addr", 32'(rom_addr), 1);
        idle(1);                   chk("s2_len_read_addr", 32'(rom_addr), 0);
        idle(1);
        for (int i = 0; i < 7; i++) begin
            step(1, 0, 0, 0, 4'h0, 0); chk("s2_env_addr", 32'(rom_addr), 32'(s2_addr[i]));
            idle(2);
            chk("s2_valid", 32'(valid), 1);
            chk("s2_amp", 32'(amplitude), 32'(s2_amps[i]));
            idle(2);
        end

        // Release
        step(0, 0, 1, 0, 4'h0, 0);
        step(1, 0, 0, 0, 4'h0, 0);
        chk("rel_valid", 32'(valid), 1);
        chk("rel_amp", 32'(amplitude), 0);
        idle(1);
        chk("rel_idle_busy", 32'(busy), 0);
        step(1, 0, 0, 0, 4'h0, 0);
        chk("rel_again_valid", 32'(valid), 1);
        chk("rel_again_amp", 32'(amplitude), 0);
        idle(1);

        // note_on beats coincident note_off; strobes while busy are dropped
        step(0, 1, 1, 1, 4'h0, 0);
        idle(2);
        got.delete();
        step(1, 0, 0, 0, 4'h0, 0);
        step(1, 0, 0, 0, 4'h0, 0);
        step(1, 0, 0, 0, 4'h0, 0);
        idle(2);
        chk("drop_count", 32'(got.size()), 1);
        if (got.size() > 0) chk("drop_amp", 32'(got[0]), 32'hC);

        // note_on during ENV_ADDR restarts without a valid
        got.delete();
        step(1, 0, 0, 0, 4'h0, 0);
        step(0, 1, 0, 1, 4'h5, 0);
        chk("restart_busy", 32'(busy), 1);
        chk("restart_valid", 32'(valid), 0);
        chk("restart_addr", 32'(rom_addr), 1);
        idle(3);
        chk("restart_no_valid", 32'(got.size()), 0);

        // Reset sampled during LEN_READ
        step(0, 1, 0, 0, 4'h0, 0);
        idle(1);
        step(0, 0, 0, 0, 4'h0, 1);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_amp", 32'(amplitude), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_addr", 32'(rom_addr), 0);
        step(1, 0, 0, 0, 4'h0, 0);
        chk("post_rst_valid", 32'(valid), 1);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
